// File: rtl/register_file.sv
// Two-read, one-write register file with a hardwired-zero entry and async active-low reset.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned ZERO_REG   = 31
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  reg_write,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2
);

   localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZeroAddr = ADDR_WIDTH'(ZERO_REG);

   logic [DATA_WIDTH-1:0] storage_q [NumRegs];
   logic [DATA_WIDTH-1:0] storage_d [NumRegs];
   logic                  wr_en;

   // Writes to the zero register are dropped here, so its entry stays at its reset value.
   assign wr_en = reg_write && (write_reg != ZeroAddr);

   always_comb begin
      storage_d = storage_q;
      if (wr_en) begin
         storage_d[write_reg] = write_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NumRegs; i++) begin
            storage_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NumRegs; i++) begin
            storage_q[i] <= storage_d[i];
         end
      end
   end

   function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic                  rst_n,
                                                        input logic                  we);
      logic [DATA_WIDTH-1:0] data;
      data = storage_q[addr];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is suppressed in reset so reads stay at zero.
      if (rst_n && we && (addr == write_reg)) begin
         data = write_data;
      end
`else
      if (rst_n && we) begin
         data = storage_q[addr];
      end
`endif
      if (addr == ZeroAddr) begin
         data = '0;
      end
      return data;
   endfunction

   always_comb begin
      read_data1 = read_port(read_reg1, reset_n, wr_en);
      read_data2 = read_port(read_reg2, reset_n, wr_en);
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_register_file;

   localparam int DW = 64;
   localparam int AW = 5;
   localparam int NR = 32;
   localparam int ZR = 31;

   logic          clk;
   logic          reset_n;
   logic [AW-1:0] read_reg1;
   logic [AW-1:0] read_reg2;
   logic [AW-1:0] write_reg;
   logic [DW-1:0] write_data;
   logic          reg_write;
   logic [DW-1:0] read_data1;
   logic [DW-1:0] read_data2;

   logic [DW-1:0] model [NR];
   int            n_checks;
   int            n_fail;

   register_file #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .ZERO_REG  (ZR)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .read_reg1 (read_reg1),
      .read_reg2 (read_reg2),
      .write_reg (write_reg),
      .write_data(write_data),
      .reg_write (reg_write),
      .read_data1(read_data1),
      .read_data2(read_data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   function automatic logic [DW-1:0] expect_read(input int addr);
      if (addr == ZR) return '0;
      if (!reset_n) return '0;
      if (Bypass && reg_write && (int'(write_reg) == addr)) return write_data;
      return model[addr];
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reads(input string tag);
      #1;
      check({tag, "_rd1"}, read_data1, expect_read(int'(read_reg1)));
      check({tag, "_rd2"}, read_data2, expect_read(int'(read_reg2)));
   endtask

   // One rising edge; the model commits whatever the inputs request at that edge.
   task automatic step();
      @(posedge clk);
      if (reset_n && reg_write && (int'(write_reg) != ZR)) model[write_reg] = write_data;
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) model[i] = '0;
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      model_reset();
      reset_n    = 1'b0;
      reg_write  = 1'b1;
      write_reg  = 5'd4;
      write_data = 64'hCAFE_F00D_1234_5678;
      read_reg1  = '0;
      read_reg2  = '0;

      // Reset held: every address reads zero, even with a write requested.
      for (int a = 0; a < NR; a++) begin
         read_reg1 = AW'(a);
         read_reg2 = AW'(NR - 1 - a);
         write_reg = AW'(a);
         check_reads("reset_hold");
      end
      step();
      step();
      read_reg1 = 5'd4;
      check_reads("reset_write_lost");

      // Release between edges, no writes.
      #2;
      reset_n   = 1'b1;
      reg_write = 1'b0;
      step();
      for (int a = 0; a < NR; a++) begin
         read_reg1 = AW'(a);
         read_reg2 = AW'(a);
         check_reads("post_reset");
      end

      // Basic write/read on X5, X6 untouched.
      reg_write  = 1'b1;
      write_reg  = 5'd5;
      write_data = 64'h0123_4567_89AB_CDEF;
      step();
      reg_write  = 1'b0;
      read_reg1  = 5'd5;
      read_reg2  = 5'd5;
      check_reads("x5");
      check("x5_lit", read_data1, 64'h0123_4567_89AB_CDEF);
      read_reg2  = 5'd6;
      check_reads("x6");

      // Zero register discards writes.
      reg_write  = 1'b1;
      write_reg  = 5'd31;
      write_data = '1;
      read_reg1  = 5'd31;
      read_reg2  = 5'd31;
      check_reads("xzr_pre");
      step();
      reg_write  = 1'b0;
      check_reads("xzr_post");
      check("xzr_lit", read_data2, 64'h0);

      // Write enable low leaves X7 alone.
      write_reg  = 5'd7;
      write_data = 64'hDEAD;
      read_reg1  = 5'd7;
      step();
      check_reads("we_low");
      check("we_low_lit", read_data1, 64'h0);

      // Same-cycle read/write on X9.
      reg_write  = 1'b1;
      write_reg  = 5'd9;
      write_data = 64'h55;
      read_reg1  = 5'd9;
      read_reg2  = 5'd9;
      check_reads("rw9_pre");
      check("rw9_pre_lit", read_data1, Bypass ? 64'h55 : 64'h0);
      step();
      reg_write  = 1'b0;
      check_reads("rw9_post");
      check("rw9_post_lit", read_data1, 64'h55);

      // Async reset between edges clears immediately.
      reg_write  = 1'b1;
      write_reg  = 5'd3;
      write_data = 64'hAA;
      step();
      reg_write  = 1'b0;
      read_reg1  = 5'd3;
      check_reads("x3_written");
      #1;
      reset_n    = 1'b0;
      model_reset();
      check_reads("async_reset");
      check("async_reset_lit", read_data1, 64'h0);
      #1;
      reset_n    = 1'b1;

      // Randomized traffic, biased toward read-after-write collisions.
      for (int it = 0; it < 300; it++) begin
         reg_write  = 1'($urandom_range(0, 3) != 0);
         write_reg  = AW'($urandom);
         write_data = {$urandom, $urandom};
         read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom);
         read_reg2  = ($urandom_range(0, 3) == 0) ? write_reg : AW'($urandom);
         check_reads("rand");
         step();
      end

      // Final sweep of the whole file.
      reg_write = 1'b0;
      for (int a = 0; a < NR; a++) begin
         read_reg1 = AW'(a);
         read_reg2 = AW'((a + 7) % NR);
         check_reads("sweep");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
